// File: rtl/spart_rx_if.sv
// Processor-side view of the SPART receiver: received byte, status flags and
// the consume strobe.
interface spart_rx_if #(
  parameter int DATA_BITS = 8
);
  // Handshake: rda=1 means rx_data holds an unconsumed byte. The reader takes
  // rx_data while rda=1 and pulses clr_rda for one cycle. rda then drops on the
  // next clk. A byte that completes while rda=1 overwrites rx_data and sets
  // the overrun flag.
  logic                 clr_rda;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rda;
  logic                 framing_err;
  logic                 overrun;

  modport master (
    output clr_rda,
    input  rx_data,
    input  rda,
    input  framing_err,
    input  overrun
  );

  modport slave (
    input  clr_rda,
    output rx_data,
    output rda,
    output framing_err,
    output overrun
  );
endinterface

// File: rtl/spart_rx.sv
// SPART receiver: 8N1 deserialiser clocked by a 16x oversample tick. It holds
// the last good byte and sets rda, framing-error and overrun flags.
module spart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       brg_en,
  input  logic       rxd,
  spart_rx_if.slave  bus,
  output logic [1:0] state_dbg
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 2);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rda_q, rda_d;
  logic                 fe_q, fe_d;
  logic                 ov_q, ov_d;
  logic                 armed_q, armed_d;
  logic                 rxd_m_q, rxd_s_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_m_q    <= 1'b1;
      rxd_s_q    <= 1'b1;
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      rx_data_q  <= '0;
      rda_q      <= 1'b0;
      fe_q       <= 1'b0;
      ov_q       <= 1'b0;
      armed_q    <= 1'b1;
    end else begin
      rxd_m_q    <= rxd;
      rxd_s_q    <= rxd_m_q;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      rx_data_q  <= rx_data_d;
      rda_q      <= rda_d;
      fe_q       <= fe_d;
      ov_q       <= ov_d;
      armed_q    <= armed_d;
    end
  end

  // armed blocks a start until the line has been seen high once after a
  // low stop bit, so a held break cannot retrigger frames.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    rx_data_d  = rx_data_q;
    rda_d      = rda_q;
    fe_d       = fe_q;
    ov_d       = ov_q;
    armed_d    = armed_q;

    if (bus.clr_rda) begin
      rda_d = 1'b0;
      fe_d  = 1'b0;
      ov_d  = 1'b0;
    end

    if (brg_en) begin
      case (state_q)
        IDLE: begin
          if (rxd_s_q) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d    = START;
            tick_cnt_d = '0;
          end
        end
        START: begin
          if (tick_cnt_q == HALF_LAST) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = rxd_s_q ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        DATA: begin
          if (tick_cnt_q == BIT_LAST) begin
            tick_cnt_d = '0;
            shreg_d    = {rxd_s_q, shreg_q[DATA_BITS-1:1]};
            bit_cnt_d  = bit_cnt_q + BW'(1);
            if (bit_cnt_q == DATA_LAST) state_d = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        STOP: begin
          if (tick_cnt_q == BIT_LAST) begin
            tick_cnt_d = '0;
            state_d    = IDLE;
            armed_d    = rxd_s_q;
            if (rxd_s_q) begin
              // Completion overrides a coincident clr_rda.
              rx_data_d = shreg_q;
              rda_d     = 1'b1;
              if (rda_q && !bus.clr_rda) ov_d = 1'b1;
            end else begin
              fe_d = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.rx_data     = rx_data_q;
  assign bus.rda         = rda_q;
  assign bus.framing_err = fe_q;
  assign bus.overrun     = ov_q;
  assign state_dbg       = state_q;
endmodule

// File: tb/tb_spart_rx.sv
// Bench for spart_rx: tick generator, frame driver, byte scoreboard,
// vector table for the single-frame cases and hand-written corner sequences.
module tb_spart_rx;
  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       brg_en = 1'b0;
  logic       rxd = 1'b1;
  logic [1:0] state_dbg;

  spart_rx_if bus ();

  spart_rx dut (
    .clk       (clk),
    .rst       (rst),
    .brg_en    (brg_en),
    .rxd       (rxd),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock and tick ----------------
  always #5 clk = ~clk;

  int tick_phase = 0;
  initial forever begin
    @(posedge clk);
    #2;
    tick_phase = (tick_phase + 1) % 4;
    brg_en     = (tick_phase == 0);
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic       rda_prev  = 1'b0;
  logic [7:0] data_prev = 8'h00;
  time        t_start = 0;
  time        t_rda   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      rda_prev  = 1'b0;
      data_prev = 8'h00;
    end else begin
      if (bus.rda && (!rda_prev || bus.rx_data != data_prev)) begin
        if (!rda_prev) t_rda = $time;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got %02h with nothing pending", bus.rx_data);
        end else begin
          check("sb_byte", {24'h0, bus.rx_data}, {24'h0, exp_q.pop_front()});
        end
      end
      rda_prev  = bus.rda;
      data_prev = bus.rx_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic align_tick();
    int guard = 0;
    @(negedge clk);
    while (!brg_en && guard < 16) begin
      @(negedge clk);
      guard++;
    end
    if (!brg_en) begin
      n_checks++;
      n_fail++;
      $display("FAIL align: brg_en got 0 expected 1 within 16 clk");
    end
  endtask

  // Frame starts on the negedge just before a tick; clr_at >= 0 pulses
  // clr_rda at that clk index counted from the start-bit edge.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int bit_clks,
                            input int offset, input int clr_at);
    logic [9:0] bits;
    bits = {stop_v, d, 1'b0};
    align_tick();
    repeat (offset) @(negedge clk);
    t_start = $time;
    for (int c = 0; c < 10 * bit_clks; c++) begin
      rxd = bits[c / bit_clks];
      if (clr_at >= 0) bus.clr_rda = (c == clr_at);
      @(negedge clk);
    end
    bus.clr_rda = 1'b0;
    rxd = 1'b1;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.clr_rda = 1'b1;
    @(negedge clk);
    bus.clr_rda = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_out(input string tag, input logic [7:0] d, input logic r,
                           input logic fe, input logic ov);
    check({tag, "_rx_data"}, {24'h0, bus.rx_data}, {24'h0, d});
    check({tag, "_rda"}, {31'h0, bus.rda}, {31'h0, r});
    check({tag, "_framing_err"}, {31'h0, bus.framing_err}, {31'h0, fe});
    check({tag, "_overrun"}, {31'h0, bus.overrun}, {31'h0, ov});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       clr_after;
    logic       chk_lat;
    logic [7:0] exp_data;
    logic       exp_rda;
    logic       exp_fe;
    logic       exp_ov;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h81, 1'b1, 1'b0, 1'b0, 8'h81, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h7E, 1'b1, 1'b1, 1'b0, 8'h7E, 1'b1, 1'b0, 1'b1};

    bus.clr_rda = 1'b0;
    #1;
    check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    check("reset_state", {30'h0, state_dbg}, 32'd0);
    #22 rst = 1'b1;
    idle(20);

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].stop) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop, BIT_CLKS, 0, -1);
      if (vecs[i].chk_lat) check("rda_latency", 32'((t_rda - t_start) / 10), 32'd609);
      idle(2 * BIT_CLKS);
      check_out($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_rda,
                vecs[i].exp_fe, vecs[i].exp_ov);
      if (vecs[i].clr_after) begin
        pulse_clr();
        check_out($sformatf("vec%0d_clr", i), vecs[i].exp_data, 1'b0, 1'b0, 1'b0);
      end
    end

    // Short low pulse must be rejected at the start-bit centre.
    align_tick();
    rxd = 1'b0;
    idle(12);
    rxd = 1'b1;
    idle(100);
    check("glitch_state", {30'h0, state_dbg}, 32'd0);
    check_out("glitch", 8'h7E, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(8'h00);
    send_frame(8'h00, 1'b1, BIT_CLKS, 0, -1);
    idle(2 * BIT_CLKS);
    check_out("after_glitch", 8'h00, 1'b1, 1'b0, 1'b0);
    pulse_clr();

    // Back-to-back without consuming: overrun.
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, BIT_CLKS, 0, -1);
    exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b1, BIT_CLKS, 0, -1);
    idle(2 * BIT_CLKS);
    check_out("overrun", 8'h22, 1'b1, 1'b0, 1'b1);
    pulse_clr();
    check_out("overrun_clr", 8'h22, 1'b0, 1'b0, 1'b0);

    // Same, with clr_rda landing on the completion edge of the second byte.
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, BIT_CLKS, 0, -1);
    exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b1, BIT_CLKS, 0, 608);
    idle(2 * BIT_CLKS);
    check_out("clr_at_done", 8'h22, 1'b1, 1'b0, 1'b0);
    pulse_clr();

    // Baud error both ways, line edges 1 clk off the tick grid.
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 62, 1, -1);
    idle(2 * BIT_CLKS);
    check_out("baud_fast", 8'hC3, 1'b1, 1'b0, 1'b0);
    pulse_clr();
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 66, 1, -1);
    idle(2 * BIT_CLKS);
    check_out("baud_slow", 8'hC3, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset after 3 data bits of 0xA5.
    align_tick();
    rxd = 1'b0;
    idle(BIT_CLKS);
    rxd = 1'b1;
    idle(BIT_CLKS);
    rxd = 1'b0;
    idle(BIT_CLKS);
    rxd = 1'b1;
    idle(BIT_CLKS);
    idle(20);
    check("midframe_state", {30'h0, state_dbg}, 32'd2);
    #3 rst = 1'b0;
    #1;
    check_out("async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    check("async_reset_state", {30'h0, state_dbg}, 32'd0);
    idle(10);
    #3 rst = 1'b1;
    idle(40);
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, BIT_CLKS, 0, -1);
    idle(2 * BIT_CLKS);
    check_out("after_reset", 8'hA5, 1'b1, 1'b0, 1'b0);

    idle(10);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
